frame_ram: RTL and testbench
============================

FRAME_RAM -- requirements
Module: frame_ram

Interface
REQ-001 Parameter H_RES, default 320, meaning displayed columns.
REQ-002 Parameter V_RES, default 240, meaning displayed rows.
REQ-003 Parameter NUMBER_COLORS, default 10, meaning palette size; CW = $clog2(NUMBER_COLORS)+1 is the pixel width.
REQ-004 Derived constants: XW = $clog2(H_RES), YW = $clog2(V_RES), AW = $clog2(H_RES*V_RES), NPIX = H_RES*V_RES.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 x  in  XW  display read column.
REQ-008 y  in  YW  display read row.
REQ-009 dout  out  CW  registered pixel from front bank.
REQ-010 waddr  in  AW  linear write address into back bank.
REQ-011 din  in  CW  write pixel.
REQ-012 we  in  1  write strobe; accepted only when wr_ready=1.
REQ-013 wr_ready  out  1  high when external writes are accepted.
REQ-014 clear_req  in  1  single-cycle pulse starting a back-bank fill.
REQ-015 clear_color  in  CW  fill value, sampled on the cycle clear_req is accepted.
REQ-016 busy  out  1  high while the fill engine runs.
REQ-017 swap_req  in  1  single-cycle pulse requesting a front/back exchange.
REQ-018 frame_start  in  1  single-cycle vertical-sync pulse from the display timing block.
REQ-019 swap_pending  out  1  swap requested but not yet performed.
REQ-020 front_sel  out  1  index (0/1) of the bank currently displayed.

Function
REQ-021 The block SHALL hold two banks of NPIX x CW words; reads use front bank front_sel, writes use bank ~front_sel.
REQ-022 Read address SHALL be y + V_RES*x (column-major); dout SHALL update one cycle after x/y are presented.
REQ-023 When x >= H_RES or y >= V_RES, dout SHALL be 0 on the following cycle.
REQ-024 An accepted write (we & wr_ready) SHALL store din at waddr in the back bank; waddr >= NPIX SHALL be ignored.
REQ-025 FSM states: IDLE, CLEAR. IDLE -> CLEAR on clear_req; CLEAR -> IDLE on the cycle the counter writes address NPIX-1.
REQ-026 In CLEAR the block SHALL write clear_color to back-bank addresses 0..NPIX-1, one per cycle, ascending; fill takes exactly NPIX cycles.
REQ-027 busy SHALL equal (state==CLEAR); wr_ready SHALL equal ~busy; we while busy SHALL be dropped, not queued.
REQ-028 clear_req while busy SHALL be ignored (no restart, no color change).
REQ-029 swap_req SHALL set swap_pending; repeated swap_req while pending SHALL have no extra effect.
REQ-030 On frame_start with swap_pending=1 and busy=0, front_sel SHALL toggle and swap_pending SHALL clear on the same edge.
REQ-031 frame_start while busy SHALL leave the swap pending until the first frame_start after the fill completes.
REQ-032 swap_req and frame_start in the same cycle SHALL not swap; the swap occurs on the next qualifying frame_start.
REQ-033 clear_req and we in the same cycle (IDLE): the write SHALL be performed; the fill starts the next cycle and overwrites it.

Reset
REQ-034 rst_n low SHALL force state=IDLE, fill counter=0, swap_pending=0, front_sel=0, dout=0, busy=0, wr_ready=1, immediately and asynchronously.
REQ-035 Reset mid-fill SHALL abort the fill; memory contents are undefined (not cleared by reset).

Structure
REQ-036 Package frame_pkg SHALL hold the FSM state enum and the default H_RES/V_RES/NUMBER_COLORS constants.
REQ-037 One sub-module, frame_bank: simple dual-port RAM (one write, one registered read), instantiated twice; bank memory SHALL have no reset.

Verification
REQ-038 Write din=5 at waddr=241 (x=1,y=1), swap_req, frame_start; read x=1,y=1 -> dout=5 one cycle later, front_sel=1.
REQ-039 clear_req with clear_color=3 -> busy high for exactly 76800 cycles; after swap on frame_start, random reads return 3.
REQ-040 we during fill at waddr=0, din=7 -> wr_ready=0, write dropped; post-swap read (0,0) returns the clear color.
REQ-041 swap_req then frame_start while busy -> front_sel unchanged, swap_pending=1; next frame_start after busy falls -> front_sel toggles, swap_pending=0.
REQ-042 Read x=320,y=0 and x=0,y=240 -> dout=0.
REQ-043 Assert rst_n low mid-fill -> busy=0, front_sel=0, swap_pending=0, dout=0 immediately; new clear_req after release starts from address 0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and default geometry for the double-buffered frame store.
package frame_pkg;

  localparam int DEF_H_RES         = 320;
  localparam int DEF_V_RES         = 240;
  localparam int DEF_NUMBER_COLORS = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/frame_bank.sv
// One frame bank: simple dual-port RAM, one write port, registered read port.
// The array and read register are left unreset so the tools map them onto block RAM.
module frame_bank #(
  parameter int DEPTH = 76800,
  parameter int AW    = 17,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_ram.sv
// Double-buffered frame store: display reads the front bank, the drawing side and the
// fill engine write the back bank, and banks exchange on a frame_start once requested.
module frame_ram
  import frame_pkg::*;
#(
  parameter int  H_RES         = DEF_H_RES,
  parameter int  V_RES         = DEF_V_RES,
  parameter int  NUMBER_COLORS = DEF_NUMBER_COLORS,
  localparam int CW            = $clog2(NUMBER_COLORS) + 1,
  localparam int XW            = $clog2(H_RES),
  localparam int YW            = $clog2(V_RES),
  localparam int AW            = $clog2(H_RES * V_RES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [CW-1:0] dout,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] din,
  input  logic          we,
  output logic          wr_ready,
  input  logic          clear_req,
  input  logic [CW-1:0] clear_color,
  output logic          busy,
  input  logic          swap_req,
  input  logic          frame_start,
  output logic          swap_pending,
  output logic          front_sel
);

  localparam int              NPIX      = H_RES * V_RES;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(NPIX - 1);
  localparam logic [XW-1:0]   X_LAST    = XW'(H_RES - 1);
  localparam logic [YW-1:0]   Y_LAST    = YW'(V_RES - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] color_q, color_d;
  logic          swap_pending_q, swap_pending_d;
  logic          front_sel_q, front_sel_d;
  logic          rd_valid_q, rd_sel_q;

  logic          in_range;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [1:0]    bank_we;
  logic [CW-1:0] bank_rd [2];

  assign busy         = (state_q == CLEAR);
  assign wr_ready     = ~busy;
  assign swap_pending = swap_pending_q;
  assign front_sel    = front_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      color_q        <= '0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_sel_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      color_q        <= color_d;
      swap_pending_q <= swap_pending_d;
      front_sel_q    <= front_sel_d;
      rd_valid_q     <= in_range;
      rd_sel_q       <= front_sel_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = clear_color;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A swap requested in the same cycle as frame_start waits for the next frame_start.
  always_comb begin
    swap_pending_d = swap_pending_q;
    front_sel_d    = front_sel_q;
    if (frame_start && swap_pending_q && !busy) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = din;
    if (busy) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = color_q;
    end else if (we && (waddr <= LAST_ADDR)) begin
      wr_en = 1'b1;
    end
    bank_we               = '0;
    bank_we[~front_sel_q] = wr_en;
  end

  // Column-major addressing; out-of-range reads park on address 0 and are masked at dout.
  always_comb begin
    in_range = (x <= X_LAST) && (y <= Y_LAST);
    rd_addr  = in_range ? (AW'(y) + AW'(V_RES) * AW'(x)) : '0;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    frame_bank #(
      .DEPTH (NPIX),
      .AW    (AW),
      .DW    (CW)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we[gi]),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (rd_addr),
      .rdata_o (bank_rd[gi])
    );
  end

  assign dout = rd_valid_q ? bank_rd[rd_sel_q] : '0;

endmodule

// File: tb/tb_frame_ram.sv
// Directed bench for frame_ram: bank writes, swap handshake, fill engine, reads and async reset.
module tb_frame_ram;

  localparam int NPIX = 320 * 240;

  logic        clk;
  logic        rst_n;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [4:0]  dout;
  logic [16:0] waddr;
  logic [4:0]  din;
  logic        we;
  logic        wr_ready;
  logic        clear_req;
  logic [4:0]  clear_color;
  logic        busy;
  logic        swap_req;
  logic        frame_start;
  logic        swap_pending;
  logic        front_sel;

  int total = 0;
  int bad   = 0;
  int n;

  frame_ram dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .dout         (dout),
    .waddr        (waddr),
    .din          (din),
    .we           (we),
    .wr_ready     (wr_ready),
    .clear_req    (clear_req),
    .clear_color  (clear_color),
    .busy         (busy),
    .swap_req     (swap_req),
    .frame_start  (frame_start),
    .swap_pending (swap_pending),
    .front_sel    (front_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic rd(input string tag, input int cx, input int cy, input logic [4:0] exp);
    x = 9'(cx);
    y = 8'(cy);
    tick();
    chk(tag, 32'(dout), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; x = '0; y = '0; waddr = '0; din = '0; we = 1'b0;
    clear_req = 1'b0; clear_color = '0; swap_req = 1'b0; frame_start = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_front_sel", 32'(front_sel), 32'd0);
    chk("rst_swap_pending", 32'(swap_pending), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write pixel (1,1) into back bank 1, then exchange banks.
    we = 1'b1; waddr = 17'd241; din = 5'd5;
    tick();
    we = 1'b0;
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("same_cycle_no_swap", 32'(front_sel), 32'd0);
    chk("same_cycle_pending", 32'(swap_pending), 32'd1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("swap_front_sel", 32'(front_sel), 32'd1);
    chk("swap_pending_clr", 32'(swap_pending), 32'd0);
    rd("read_1_1", 1, 1, 5'd5);
    rd("read_x_oob", 320, 0, 5'd0);
    rd("read_y_oob", 0, 240, 5'd0);
    rd("read_1_1_again", 1, 1, 5'd5);

    // Start a fill of bank 0 and reset in the middle of it.
    clear_req = 1'b1; clear_color = 5'd1;
    tick();
    clear_req = 1'b0;
    chk("fill1_busy", 32'(busy), 32'd1);
    chk("fill1_wr_ready", 32'(wr_ready), 32'd0);
    repeat (50) tick();
    chk("fill1_front_dout", 32'(dout), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
    chk("midrst_front_sel", 32'(front_sel), 32'd0);
    chk("midrst_swap_pending", 32'(swap_pending), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full fill of bank 1 with color 3; a write in the clear_req cycle gets overwritten.
    clear_req = 1'b1; clear_color = 5'd3; we = 1'b1; waddr = 17'd5; din = 5'd6;
    tick();
    clear_req = 1'b0; we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100000) begin
      n++;
      if (n == 10) begin
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        we = 1'b1; waddr = 17'd0; din = 5'd7;
      end
      if (n == 20) begin
        clear_req = 1'b1; clear_color = 5'd4;
      end
      if (n == 30) swap_req = 1'b1;
      if (n == 40) frame_start = 1'b1;
      if (n == 41) begin
        chk("busy_swap_front_sel", 32'(front_sel), 32'd0);
        chk("busy_swap_pending", 32'(swap_pending), 32'd1);
      end
      tick();
      we = 1'b0; clear_req = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
    end
    chk("fill_busy_cycles", 32'(n), 32'(NPIX));
    chk("after_fill_front_sel", 32'(front_sel), 32'd0);
    chk("after_fill_pending", 32'(swap_pending), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("post_fill_swap_front", 32'(front_sel), 32'd1);
    chk("post_fill_swap_pending", 32'(swap_pending), 32'd0);
    rd("fill_read_0_0", 0, 0, 5'd3);
    rd("fill_read_0_5", 0, 5, 5'd3);
    rd("fill_read_1_1", 1, 1, 5'd3);
    rd("fill_read_last", 319, 239, 5'd3);
    for (int i = 0; i < 4; i++) begin
      rd("fill_read_rand", int'($urandom_range(319)), int'($urandom_range(239)), 5'd3);
    end
    rd("fill_read_oob", 320, 239, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
